// File: rtl/alu_exec_pkg.sv
// Shared ALU control encoding and execute-stage types, also used by the ARM-op-to-ALU adapter.
// Consumed by alu_core and alu_exec_stage (optional skid buffer: EXEC_SKID_EN).
package alu_exec_pkg;

  typedef logic [3:0] alu_ctrl_t;

  localparam alu_ctrl_t ALU_ADD = 4'b0000;
  localparam alu_ctrl_t ALU_SUB = 4'b0001;
  localparam alu_ctrl_t ALU_AND = 4'b0111;
  localparam alu_ctrl_t ALU_XOR = 4'b1001;

  localparam int EXEC_WIDTH = 32;
  localparam int EXEC_RD_W  = 4;

  typedef struct packed {
    logic n;
    logic z;
    logic c;
    logic v;
  } nzcv_t;

  // Default-width beat view for neighbours that do not override WIDTH/RD_W.
  typedef struct packed {
    logic [EXEC_WIDTH-1:0] result;
    logic [EXEC_RD_W-1:0]  rd;
    logic                  wb_en;
    logic                  err;
  } exec_beat_t;

  function automatic logic is_arith(alu_ctrl_t ctrl);
    return (ctrl == ALU_ADD) || (ctrl == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_exec_stage_alu_core.sv
// Combinational ALU datapath: result, candidate NZCV and illegal-code flag.
// Logical ops pass the previous C/V through so the caller can write NZCV uniformly.
module alu_core
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  alu_ctrl_t        ctrl_i,
  input  logic             prev_c_i,
  input  logic             prev_v_i,
  output logic [WIDTH-1:0] result_o,
  output nzcv_t            nzcv_o,
  output logic             err_o
);

  logic             is_sub;
  logic [WIDTH-1:0] b_op;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // SUB is a + ~b + 1, so carry out is the ARM "no borrow" flag.
  assign is_sub = (ctrl_i == ALU_SUB);
  assign b_op   = is_sub ? ~b_i : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_op} + {{WIDTH{1'b0}}, is_sub};
  assign ovf    = (a_i[WIDTH-1] == b_op[WIDTH-1]) && (sum[WIDTH-1] != a_i[WIDTH-1]);

  always_comb begin
    result_o = '0;
    nzcv_o.c = prev_c_i;
    nzcv_o.v = prev_v_i;
    err_o    = 1'b0;
    if (is_arith(ctrl_i)) begin
      result_o = sum[WIDTH-1:0];
      nzcv_o.c = sum[WIDTH];
      nzcv_o.v = ovf;
    end else begin
      case (ctrl_i)
        ALU_AND: result_o = a_i & b_i;
        ALU_XOR: result_o = a_i ^ b_i;
        default: err_o    = 1'b1;
      endcase
    end
    nzcv_o.n = result_o[WIDTH-1];
    nzcv_o.z = (result_o == '0);
  end

endmodule

// File: rtl/alu_exec_stage.sv
// Registered ALU execute stage: NZCV flags register plus output register or, with
// EXEC_SKID_EN defined, a 2-entry skid buffer with a registered in_ready.
module alu_exec_stage
  import alu_exec_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RD_W  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_ctrl_t        in_alu_ctrl,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [RD_W-1:0]  in_rd,
  input  logic             in_wb_en,
  input  logic             in_set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [RD_W-1:0]  out_rd,
  output logic             out_wb_en,
  output logic             out_err,
  output logic [3:0]       flags_nzcv
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [RD_W-1:0]  rd;
    logic             wb_en;
    logic             err;
  } beat_t;

  // Handshake: a beat transfers on a rising edge where valid & ready are both high;
  // valid never depends on ready, and a presented beat stays stable until it transfers.
  logic             accept;
  logic [WIDTH-1:0] core_result;
  nzcv_t            core_nzcv;
  logic             core_err;
  nzcv_t            flags_q;
  beat_t            new_beat;
  beat_t            head_q;

  assign accept = in_valid & in_ready;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a_i      (in_a),
    .b_i      (in_b),
    .ctrl_i   (in_alu_ctrl),
    .prev_c_i (flags_q.c),
    .prev_v_i (flags_q.v),
    .result_o (core_result),
    .nzcv_o   (core_nzcv),
    .err_o    (core_err)
  );

  assign new_beat = '{result: core_result, rd: in_rd, wb_en: in_wb_en, err: core_err};

  // Flags follow program order at accept time, regardless of any output stall.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags_q <= '0;
    end else if (accept && in_set_flags && !core_err) begin
      flags_q <= core_nzcv;
    end
  end

  assign flags_nzcv = flags_q;

`ifdef EXEC_SKID_EN
  logic [1:0] count_q, count_d;
  beat_t      skid_q, skid_d, head_d;
  logic       in_ready_q;
  logic       pop;

  assign pop = (count_q != 2'd0) & out_ready;

  always_comb begin
    count_d = count_q;
    head_d  = head_q;
    skid_d  = skid_q;
    case ({accept, pop})
      2'b10: begin
        if (count_q == 2'd0) head_d = new_beat;
        else                 skid_d = new_beat;
        count_d = 2'(count_q + 2'd1);
      end
      2'b01: begin
        head_d  = skid_q;
        count_d = 2'(count_q - 2'd1);
      end
      // Accept is only possible below two entries, so head drains into the new beat.
      2'b11: head_d = (count_q == 2'd2) ? skid_q : new_beat;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q    <= 2'd0;
      head_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      count_q    <= count_d;
      head_q     <= head_d;
      skid_q     <= skid_d;
      in_ready_q <= (count_d != 2'd2);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = (count_q != 2'd0);
`else
  logic out_valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      head_q      <= '0;
    end else if (accept) begin
      out_valid_q <= 1'b1;
      head_q      <= new_beat;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign in_ready  = ~out_valid_q | out_ready;
  assign out_valid = out_valid_q;
`endif

  assign out_result = head_q.result;
  assign out_rd     = head_q.rd;
  assign out_wb_en  = head_q.wb_en;
  assign out_err    = head_q.err;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: scoreboard of expected beats plus an NZCV model.
module tb_alu_exec_stage;
  import alu_exec_pkg::*;

  localparam int W  = 32;
  localparam int RW = 4;
  localparam int BW = W + RW + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [3:0]    in_alu_ctrl = 4'h0;
  logic [W-1:0]  in_a = '0;
  logic [W-1:0]  in_b = '0;
  logic [RW-1:0] in_rd = '0;
  logic          in_wb_en = 1'b0;
  logic          in_set_flags = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_result;
  logic [RW-1:0] out_rd;
  logic          out_wb_en;
  logic          out_err;
  logic [3:0]    flags_nzcv;

  int checks = 0;
  int errors = 0;
  logic [BW-1:0] exp_q[$];
  logic [3:0]    exp_flags = 4'b0000;

  always #5 clk = ~clk;

  alu_exec_stage #(.WIDTH(W), .RD_W(RW)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_alu_ctrl(in_alu_ctrl),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .in_wb_en(in_wb_en), .in_set_flags(in_set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rd(out_rd), .out_wb_en(out_wb_en), .out_err(out_err), .flags_nzcv(flags_nzcv)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Reference model: 64-bit integer arithmetic, ARM flag semantics.
  task automatic model_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [RW-1:0] rd, input logic wb, input logic sf,
                          output logic [BW-1:0] beat);
    longint sa, sb, ss;
    longint unsigned ua, ub;
    logic [W-1:0] res;
    logic n, z, c, v, legal;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'(a);
    ub = longint'(b);
    c = exp_flags[1];
    v = exp_flags[0];
    legal = 1'b1;
    res = '0;
    case (ctrl)
      4'b0000: begin
        ss  = sa + sb;
        res = W'(ua + ub);
        c   = (ua + ub) > 64'h0000_0000_FFFF_FFFF;
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'b0001: begin
        ss  = sa - sb;
        res = a - b;
        c   = (a >= b);
        v   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
      end
      4'b0111: res = a & b;
      4'b1001: res = a ^ b;
      default: legal = 1'b0;
    endcase
    n = res[W-1];
    z = (res == '0);
    if (legal && sf) exp_flags = {n, z, c, v};
    beat = {res, rd, wb, ~legal};
  endtask

  task automatic drive_op(input logic [3:0] ctrl, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [RW-1:0] rd, input logic wb, input logic sf);
    logic [BW-1:0] beat;
    int waitc;
    bit ok;
    in_valid = 1'b1;
    in_alu_ctrl = ctrl;
    in_a = a;
    in_b = b;
    in_rd = rd;
    in_wb_en = wb;
    in_set_flags = sf;
    ok = 1'b0;
    waitc = 0;
    while (!ok && waitc < 100) begin
      @(negedge clk);
      if (in_ready === 1'b1) ok = 1'b1;
      else waitc++;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: in_ready=%b required 1 within 100 cycles", in_ready);
      in_valid = 1'b0;
      return;
    end
    model_op(ctrl, a, b, rd, wb, sf, beat);
    exp_q.push_back(beat);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (flags_nzcv !== exp_flags) begin
      errors++;
      $display("FAIL flags_after_accept: got %b required %b", flags_nzcv, exp_flags);
    end
  endtask

  // Output monitor: pops the scoreboard on each handshake and checks stall stability.
  logic [BW-1:0] held;
  bit            held_v = 1'b0;
  always @(negedge clk) begin
    logic [BW-1:0] got, e;
    got = {out_result, out_rd, out_wb_en, out_err};
    if (!rst_n) begin
      held_v = 1'b0;
    end else if (out_valid === 1'b1) begin
      if (held_v) begin
        checks++;
        if (got !== held) begin
          errors++;
          $display("FAIL hold_stable: got %h required %h", got, held);
        end
      end
      if (out_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got %h required none", got);
        end else begin
          e = exp_q.pop_front();
          if (got !== e) begin
            errors++;
            $display("FAIL beat: got %h required %h", got, e);
          end
        end
        held_v = 1'b0;
      end else begin
        held = got;
        held_v = 1'b1;
      end
    end else begin
      held_v = 1'b0;
    end
  end

  task automatic wait_drain();
    int waitc;
    waitc = 0;
    while (exp_q.size() != 0 && waitc < 60) begin
      @(negedge clk);
      waitc++;
    end
    @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d beats outstanding, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, out_wb_en, out_err} !== 3'b000) begin
      errors++;
      $display("FAIL reset_ctrl: valid/wb/err=%b required 000", {out_valid, out_wb_en, out_err});
    end
    checks++;
    if (out_result !== '0 || out_rd !== '0) begin
      errors++;
      $display("FAIL reset_data: result=%h rd=%h required 0", out_result, out_rd);
    end
    checks++;
    if (flags_nzcv !== 4'b0000) begin
      errors++;
      $display("FAIL reset_flags: got %b required 0000", flags_nzcv);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    drive_op(ALU_ADD, 32'h7FFF_FFFF, 32'h1, 4'd3, 1'b1, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_result !== 32'h8000_0000) begin
      errors++;
      $display("FAIL add_result: valid=%b result=%h required 1/80000000", out_valid, out_result);
    end
    checks++;
    if (flags_nzcv !== 4'b1001) begin
      errors++;
      $display("FAIL add_flags: got %b required 1001", flags_nzcv);
    end
    wait_drain();
  endtask

  task automatic test_sub_equal();
    drive_op(ALU_SUB, 32'd5, 32'd5, 4'd7, 1'b0, 1'b1);
    checks++;
    if (out_valid !== 1'b1 || out_wb_en !== 1'b0 || out_result !== '0) begin
      errors++;
      $display("FAIL sub_eq_beat: valid=%b wb=%b result=%h required 1/0/0", out_valid, out_wb_en, out_result);
    end
    checks++;
    if (flags_nzcv !== 4'b0110) begin
      errors++;
      $display("FAIL sub_eq_flags: got %b required 0110", flags_nzcv);
    end
    wait_drain();
  endtask

  task automatic test_illegal();
    drive_op(4'b0011, 32'h1234, 32'h5, 4'd2, 1'b1, 1'b1);
    checks++;
    if (out_err !== 1'b1 || out_result !== '0) begin
      errors++;
      $display("FAIL illegal_beat: err=%b result=%h required 1/0", out_err, out_result);
    end
    checks++;
    if (flags_nzcv !== 4'b0110) begin
      errors++;
      $display("FAIL illegal_flags: got %b required 0110", flags_nzcv);
    end
    wait_drain();
  endtask

  task automatic test_sub_then_and();
    drive_op(ALU_SUB, 32'd3, 32'd5, 4'd1, 1'b1, 1'b1);
    checks++;
    if (flags_nzcv !== 4'b1000) begin
      errors++;
      $display("FAIL sub_neg_flags: got %b required 1000", flags_nzcv);
    end
    drive_op(ALU_AND, 32'h0, 32'hF, 4'd2, 1'b1, 1'b1);
    checks++;
    if (flags_nzcv !== 4'b0100) begin
      errors++;
      $display("FAIL and_flags: got %b required 0100", flags_nzcv);
    end
    wait_drain();
  endtask

  task automatic test_back_to_back();
    fork
      begin
        for (int i = 0; i < 8; i++)
          drive_op((i % 2 == 0) ? ALU_ADD : ALU_XOR, 32'(i * 32'h1111_0001), 32'(32'hF0F0_0000 + i),
                   RW'(i), 1'b1, i[0]);
      end
      begin
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_in_ready: got %b required 0", in_ready);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_random();
    logic [3:0] codes [6];
    logic [W-1:0] a, b;
    codes[0] = ALU_ADD; codes[1] = ALU_SUB; codes[2] = ALU_AND;
    codes[3] = ALU_XOR; codes[4] = 4'b0011; codes[5] = 4'b1111;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          a = (i % 5 == 0) ? 32'h8000_0000 : $urandom;
          b = (i % 7 == 0) ? 32'hFFFF_FFFF : $urandom;
          drive_op(codes[$urandom_range(0, 5)], a, b, RW'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      begin
        repeat (60) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    wait_drain();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    drive_op(ALU_ADD, 32'd1, 32'd2, 4'd9, 1'b1, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midreset_valid: got %b required 0", out_valid);
    end
    checks++;
    if (flags_nzcv !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_flags: got %b required 0000", flags_nzcv);
    end
    exp_q.delete();
    exp_flags = 4'b0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_in_ready: got %b required 1", in_ready);
    end
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stale_beat: out_valid=%b required 0", out_valid);
    end
    drive_op(ALU_ADD, 32'd10, 32'd20, 4'd4, 1'b1, 1'b1);
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_add_overflow();
    test_sub_equal();
    test_illegal();
    test_sub_then_and();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
